// File: rtl/muldiv_pkg.sv
// Shared encodings for the iterative multiply/divide coprocessor.
package muldiv_pkg;
  localparam int MULDIV_WIDTH = 8;

  // op[OP_KIND] picks MUL/DIV, op[OP_SIGNED] requests two's-complement
  localparam int   OP_KIND   = 0;
  localparam int   OP_SIGNED = 1;
  localparam logic OP_MUL    = 1'b0;
  localparam logic OP_DIV    = 1'b1;

  localparam logic [MULDIV_WIDTH-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_e;
endpackage

// File: rtl/muldiv_if.sv
// Control-unit side bundle of the muldiv coprocessor plus its FSM state for observation.
interface muldiv_if import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_WIDTH
);
  // Handshake: start is sampled only while busy=0; an accepted start raises busy on the
  // next cycle, and done pulses for one cycle when res_*/flags become valid. A start seen
  // while busy (including the done cycle) is dropped, never queued.
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] dataA;
  logic [WIDTH-1:0] dataB;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;
  logic             cout;
  logic             zout;
  logic             nout;
  state_e           dbg_state;

  modport master (
    output start, op, dataA, dataB,
    input  busy, done, res_hi, res_lo, cout, zout, nout, dbg_state
  );

  modport slave (
    input  start, op, dataA, dataB,
    output busy, done, res_hi, res_lo, cout, zout, nout, dbg_state
  );
endinterface

// File: rtl/muldiv_signfix.sv
// Sign correction applied in FIX: negates magnitude results and reports signed overflow.
module muldiv_signfix import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input  logic             signed_i,
  input  logic             is_div_i,
  input  logic             neg_a_i,
  input  logic             neg_b_i,
  input  logic [WIDTH-1:0] hi_i,
  input  logic [WIDTH-1:0] lo_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             ovf_o
);
  logic                 flip;
  logic [2*WIDTH-1:0]   prod_neg;

  always_comb begin
    flip     = signed_i && (neg_a_i != neg_b_i);
    prod_neg = ~{hi_i, lo_i} + 1'b1;
    hi_o     = hi_i;
    lo_o     = lo_i;
    ovf_o    = 1'b0;
    if (is_div_i) begin
      // Truncating division: remainder follows the dividend's sign
      if (flip) lo_o = ~lo_i + 1'b1;
      if (signed_i && neg_a_i) hi_o = ~hi_i + 1'b1;
      if (signed_i) ovf_o = flip ? (lo_i > {1'b1, {(WIDTH-1){1'b0}}}) : lo_i[WIDTH-1];
    end else begin
      if (flip) {hi_o, lo_o} = prod_neg;
      ovf_o = signed_i ? (hi_o != {WIDTH{lo_o[WIDTH-1]}}) : (hi_o != '0);
    end
  end
endmodule

// File: rtl/muldiv_unit.sv
// Iterative shift-add multiply / restoring divide, one bit per cycle, with ALU-style flags.
// Defining MULDIV_SIGNED_EN adds signed operation via a FIX state (fixed latency accept+10).
module muldiv_unit import muldiv_pkg::*; #(
  parameter int WIDTH = MULDIV_WIDTH
) (
  input logic     clk,
  input logic     rst,
  muldiv_if.slave bus
);
  localparam int            CW       = $clog2(WIDTH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(WIDTH - 1);

  state_e            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic [WIDTH-1:0]  opr_q, opr_d;
  logic [WIDTH-1:0]  acc_hi_q, acc_hi_d;
  logic [WIDTH-1:0]  acc_lo_q, acc_lo_d;
  logic              is_div_q, is_div_d;
  logic              div0_q, div0_d;
  logic [WIDTH-1:0]  res_hi_q, res_hi_d;
  logic [WIDTH-1:0]  res_lo_q, res_lo_d;
  logic              cout_q, cout_d;
  logic              zout_q, zout_d;
  logic              nout_q, nout_d;

  logic              accept, last_iter, cap_en;
  logic [WIDTH-1:0]  a_mag, b_mag;
  logic [WIDTH-1:0]  iter_hi, iter_lo;
  logic [WIDTH-1:0]  fin_hi, fin_lo;
  logic              fin_ovf;
  logic [WIDTH:0]    mul_sum, div_shift;
  logic [WIDTH-1:0]  div_trial;
  logic              div_ge;

  assign accept    = (state_q == IDLE) && bus.start;
  assign last_iter = (cnt_q == '0);

`ifdef MULDIV_SIGNED_EN
  logic sgn_q, neg_a_q, neg_b_q;
  logic neg_a_in, neg_b_in;

  assign neg_a_in = bus.op[OP_SIGNED] && bus.dataA[WIDTH-1];
  assign neg_b_in = bus.op[OP_SIGNED] && bus.dataB[WIDTH-1];
  assign a_mag    = neg_a_in ? (~bus.dataA + 1'b1) : bus.dataA;
  assign b_mag    = neg_b_in ? (~bus.dataB + 1'b1) : bus.dataB;
  assign cap_en   = (state_q == FIX) || ((state_q == CALC) && div0_q);

  always_ff @(posedge clk) begin
    if (rst) begin
      sgn_q   <= 1'b0;
      neg_a_q <= 1'b0;
      neg_b_q <= 1'b0;
    end else if (accept) begin
      sgn_q   <= bus.op[OP_SIGNED];
      neg_a_q <= neg_a_in;
      neg_b_q <= neg_b_in;
    end
  end

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .signed_i (sgn_q),
    .is_div_i (is_div_q),
    .neg_a_i  (neg_a_q),
    .neg_b_i  (neg_b_q),
    .hi_i     (acc_hi_q),
    .lo_i     (acc_lo_q),
    .hi_o     (fin_hi),
    .lo_o     (fin_lo),
    .ovf_o    (fin_ovf)
  );
`else
  assign a_mag   = bus.dataA;
  assign b_mag   = bus.dataB;
  assign cap_en  = (state_q == CALC) && (div0_q || last_iter);
  assign fin_hi  = iter_hi;
  assign fin_lo  = iter_lo;
  assign fin_ovf = !is_div_q && (iter_hi != '0);
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = CALC;
      CALC: begin
        if (div0_q || last_iter) state_d = DONE;
`ifdef MULDIV_SIGNED_EN
        if (!div0_q && last_iter) state_d = FIX;
`endif
      end
      FIX:  state_d = DONE;
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    bus.busy      = (state_q != IDLE);
    bus.done      = (state_q == DONE);
    bus.res_hi    = res_hi_q;
    bus.res_lo    = res_lo_q;
    bus.cout      = cout_q;
    bus.zout      = zout_q;
    bus.nout      = nout_q;
    bus.dbg_state = state_q;
  end

  // One iteration: MUL adds into the upper half then shifts right; DIV shifts left and trial-subtracts
  always_comb begin
    mul_sum   = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opr_q} : '0);
    div_shift = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge    = (div_shift >= {1'b0, opr_q});
    div_trial = div_shift[WIDTH-1:0] - opr_q;
    if (is_div_q) begin
      iter_hi = div_ge ? div_trial : div_shift[WIDTH-1:0];
      iter_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end else begin
      iter_hi = mul_sum[WIDTH:1];
      iter_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end
  end

  always_comb begin
    cnt_d    = cnt_q;
    opr_d    = opr_q;
    acc_hi_d = acc_hi_q;
    acc_lo_d = acc_lo_q;
    is_div_d = is_div_q;
    div0_d   = div0_q;
    res_hi_d = res_hi_q;
    res_lo_d = res_lo_q;
    cout_d   = cout_q;
    zout_d   = zout_q;
    nout_d   = nout_q;
    if (accept) begin
      is_div_d = (bus.op[OP_KIND] == OP_DIV);
      div0_d   = is_div_d && (bus.dataB == '0);
      opr_d    = is_div_d ? b_mag : a_mag;
      acc_lo_d = is_div_d ? a_mag : b_mag;
      // Divide-by-zero keeps the raw dividend here so it can be returned as the remainder
      acc_hi_d = div0_d ? bus.dataA : '0;
      cnt_d    = CNT_LOAD;
    end else if ((state_q == CALC) && !div0_q) begin
      acc_hi_d = iter_hi;
      acc_lo_d = iter_lo;
      cnt_d    = cnt_q - 1'b1;
    end
    if (cap_en) begin
      if (div0_q) begin
        res_hi_d = acc_hi_q;
        res_lo_d = DIV0_QUOT;
        cout_d   = 1'b1;
        zout_d   = 1'b0;
        nout_d   = 1'b1;
      end else begin
        res_hi_d = fin_hi;
        res_lo_d = fin_lo;
        cout_d   = fin_ovf;
        zout_d   = is_div_q ? (fin_lo == '0) : ({fin_hi, fin_lo} == '0);
        nout_d   = is_div_q ? fin_lo[WIDTH-1] : fin_hi[WIDTH-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q    <= '0;
      opr_q    <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      is_div_q <= 1'b0;
      div0_q   <= 1'b0;
      res_hi_q <= '0;
      res_lo_q <= '0;
      cout_q   <= 1'b0;
      zout_q   <= 1'b0;
      nout_q   <= 1'b0;
    end else begin
      cnt_q    <= cnt_d;
      opr_q    <= opr_d;
      acc_hi_q <= acc_hi_d;
      acc_lo_q <= acc_lo_d;
      is_div_q <= is_div_d;
      div0_q   <= div0_d;
      res_hi_q <= res_hi_d;
      res_lo_q <= res_lo_d;
      cout_q   <= cout_d;
      zout_q   <= zout_d;
      nout_q   <= nout_d;
    end
  end
endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: driver pushes expected results, a monitor checks each done pulse.
module tb_muldiv_unit;
  import muldiv_pkg::*;

  localparam int W     = 8;
  localparam int EXP_W = 2*W + 3;
`ifdef MULDIV_SIGNED_EN
  localparam int LAT = 9;
`else
  localparam int LAT = 8;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  logic [EXP_W-1:0] exp_q[$];
  string            name_q[$];
  logic [EXP_W-1:0] mon_exp, mon_act;
  string            mon_name;

  muldiv_if #(.WIDTH(W)) bus ();

  muldiv_unit #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  function automatic logic [EXP_W-1:0] pack(input logic [W-1:0] hi, input logic [W-1:0] lo,
                                            input logic c, input logic z, input logic n);
    return {hi, lo, c, z, n};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic scramble_inputs();
    bus.op    = 2'($urandom_range(0, 3));
    bus.dataA = 8'($urandom_range(0, 255));
    bus.dataB = 8'($urandom_range(0, 255));
  endtask

  // Presents one start at the next edge (E0) and returns #1 after it with junk on the operands
  task automatic drive_start(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = op;
    bus.dataA = a;
    bus.dataB = b;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    scramble_inputs();
  endtask

  task automatic run_op(input string name, input logic [1:0] op, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [W-1:0] ehi, input logic [W-1:0] elo,
                        input logic ec, input logic ez, input logic en, input int elat,
                        input int poke, input bit poke_done);
    int lat;
    exp_q.push_back(pack(ehi, elo, ec, ez, en));
    name_q.push_back(name);
    drive_start(op, a, b);
    check({name, "_busy"}, bus.busy, 1);
    lat = 0;
    for (int k = 1; k <= 40 && lat == 0; k++) begin
      if (k == poke) begin
        @(negedge clk);
        bus.start = 1'b1;
        scramble_inputs();
      end
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      if (bus.done) lat = k;
    end
    check({name, "_latency"}, lat, elat);
    if (poke_done) begin
      @(negedge clk);
      bus.start = 1'b1;
      scramble_inputs();
    end
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check({name, "_idle"}, bus.busy, 0);
    check({name, "_hold"}, {bus.res_hi, bus.res_lo}, {ehi, elo});
  endtask

  initial begin
    int first, second;
    bit saw_done;
    bus.start = 1'b0;
    bus.op    = 2'b00;
    bus.dataA = '0;
    bus.dataB = '0;

    fork
      forever begin
        @(negedge clk);
        if (!rst && bus.done) begin
          checks++;
          if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_done: got done=1, expected no pending result");
          end else begin
            mon_exp  = exp_q.pop_front();
            mon_name = name_q.pop_front();
            mon_act  = pack(bus.res_hi, bus.res_lo, bus.cout, bus.zout, bus.nout);
            if (mon_act !== mon_exp) begin
              errors++;
              $display("FAIL %s: got hi=%02h lo=%02h c=%0b z=%0b n=%0b, expected hi=%02h lo=%02h c=%0b z=%0b n=%0b",
                       mon_name, mon_act[EXP_W-1 -: W], mon_act[2 +: W], mon_act[2], mon_act[1], mon_act[0],
                       mon_exp[EXP_W-1 -: W], mon_exp[2 +: W], mon_exp[2], mon_exp[1], mon_exp[0]);
            end
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    check("reset_outputs", {bus.busy, bus.done, bus.res_hi, bus.res_lo, bus.cout, bus.zout, bus.nout}, 0);
    check("reset_state", bus.dbg_state, IDLE);
    rst = 1'b0;

    run_op("mul_0f_11", 2'b00, 8'h0F, 8'h11, 8'h00, 8'hFF, 1'b0, 1'b0, 1'b0, LAT, 0, 1'b0);
    run_op("mul_ff_ff", 2'b00, 8'hFF, 8'hFF, 8'hFE, 8'h01, 1'b1, 1'b0, 1'b1, LAT, 0, 1'b0);
    run_op("mul_00_37", 2'b00, 8'h00, 8'h37, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0, LAT, 0, 1'b0);
    run_op("mul_80_02", 2'b00, 8'h80, 8'h02, 8'h01, 8'h00, 1'b1, 1'b0, 1'b0, LAT, 0, 1'b0);
    run_op("div_64_07", 2'b01, 8'h64, 8'h07, 8'h02, 8'h0E, 1'b0, 1'b0, 1'b0, LAT, 0, 1'b1);
    run_op("div_05_09", 2'b01, 8'h05, 8'h09, 8'h05, 8'h00, 1'b0, 1'b1, 1'b0, LAT, 0, 1'b0);
    run_op("div_c8_0a_poke", 2'b01, 8'hC8, 8'h0A, 8'h00, 8'h14, 1'b0, 1'b0, 1'b0, LAT, 3, 1'b0);
    run_op("div_55_00", 2'b01, 8'h55, 8'h00, 8'h55, 8'hFF, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0);

    // DIV aborted by reset at E5 after an ignored start at E3
    drive_start(2'b01, 8'h64, 8'h07);
    @(posedge clk);
    @(posedge clk);
    @(negedge clk);
    bus.start = 1'b1;
    scramble_inputs();
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    check("abort_busy_e3", bus.busy, 1);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    check("abort_outputs", {bus.busy, bus.done, bus.res_hi, bus.res_lo, bus.cout, bus.zout, bus.nout}, 0);
    check("abort_state", bus.dbg_state, IDLE);
    saw_done = 1'b0;
    repeat (12) begin
      @(posedge clk);
      #1;
      if (bus.done) saw_done = 1'b1;
    end
    check("abort_no_done", saw_done, 0);
    run_op("mul_03_04", 2'b00, 8'h03, 8'h04, 8'h00, 8'h0C, 1'b0, 1'b0, 1'b0, LAT, 0, 1'b0);

`ifdef MULDIV_SIGNED_EN
    run_op("smul_fe_03", 2'b10, 8'hFE, 8'h03, 8'hFF, 8'hFA, 1'b0, 1'b0, 1'b1, LAT, 0, 1'b0);
    run_op("sdiv_f9_02", 2'b11, 8'hF9, 8'h02, 8'hFF, 8'hFD, 1'b0, 1'b0, 1'b1, LAT, 0, 1'b0);
    run_op("sdiv_80_ff", 2'b11, 8'h80, 8'hFF, 8'h00, 8'h80, 1'b1, 1'b0, 1'b1, LAT, 0, 1'b0);
    run_op("sdiv_80_00", 2'b11, 8'h80, 8'h00, 8'h80, 8'hFF, 1'b1, 1'b0, 1'b1, 1, 0, 1'b0);
`else
    run_op("mul_fe_03_op1", 2'b10, 8'hFE, 8'h03, 8'h02, 8'hFA, 1'b1, 1'b0, 1'b0, LAT, 0, 1'b0);
`endif

    // start held high: accepted again as soon as the FSM is back in IDLE
    exp_q.push_back(pack(8'h00, 8'h1E, 1'b0, 1'b0, 1'b0));
    name_q.push_back("held_mul_1");
    exp_q.push_back(pack(8'h00, 8'h1E, 1'b0, 1'b0, 1'b0));
    name_q.push_back("held_mul_2");
    @(negedge clk);
    bus.start = 1'b1;
    bus.op    = 2'b00;
    bus.dataA = 8'h05;
    bus.dataB = 8'h06;
    first  = 0;
    second = 0;
    for (int k = 1; k <= 60 && second == 0; k++) begin
      @(posedge clk);
      #1;
      if (bus.done) begin
        if (first == 0) first = k;
        else second = k;
      end
    end
    bus.start = 1'b0;
    check("held_first_done", first, LAT + 1);
    check("held_second_done", second, 2*LAT + 3);
    repeat (4) @(posedge clk);
    #1;
    check("held_idle", bus.busy, 0);
    check("queue_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/muldiv_unit.md
Name: muldiv_unit

Overview:
Iterative multicycle multiply/divide coprocessor beside the 8-bit CPU ALU. It covers the arithmetic the single-cycle ALU cannot: 8x8→16 multiply and 8/8 divide with remainder.
- The control unit drives it with a start/done handshake.
- It returns results plus C/Z/N flags in the ALU's flag convention, so they feed the same status-register path.
- It uses shift-and-add / restoring-divide, one bit per cycle.

Parameters:
WIDTH, 8, operand width in bits; iteration count equals WIDTH; product/remainder pair is 2*WIDTH.

Ports:
clk  in  1  system clock, all state on rising edge
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
op  in  2  op[0]: 0=MUL, 1=DIV; op[1]: signed select (see Optional Feature)
dataA  in  WIDTH  multiplicand / dividend; captured on accepted start
dataB  in  WIDTH  multiplier / divisor; captured on accepted start
busy  out  1  high in every state except IDLE
done  out  1  one-cycle pulse; results valid from this cycle on
res_hi  out  WIDTH  MUL: product[15:8]; DIV: remainder
res_lo  out  WIDTH  MUL: product[7:0]; DIV: quotient
cout  out  1  MUL: res_hi != 0 (unsigned overflow of 8-bit result); DIV: divide-by-zero or signed overflow
zout  out  1  MUL: full 16-bit product == 0; DIV: quotient == 0
nout  out  1  MUL: product bit 15; DIV: quotient bit 7

Behaviour:
- Reset: state=IDLE; busy=0, done=0, res_hi=res_lo=0, cout=zout=nout=0; internal counter/accumulators cleared. Reset mid-operation aborts immediately and gives no done.
- States: IDLE → CALC → (FIX, macro only) → DONE → IDLE.
- IDLE, start=1 at edge E0:
  - latch operands and op;
  - load counter = WIDTH-1;
  - go to CALC.
- CALC: one iteration per edge, WIDTH iterations (edges E1..E8); counter decrements; CALC→next state when counter==0 on that edge.
  - MUL: if multiplier LSB set, add multiplicand to upper half of 2*WIDTH accumulator (carry kept in a WIDTH+1 adder); then shift right.
  - DIV: shift {rem,quot} left; trial-subtract divisor from rem (WIDTH+1 bits); on non-negative result commit it and set quot LSB.
- DONE: done=1 for exactly one cycle (cycle after E8 without macro). res_*/flags are registered when entering DONE. Next edge returns to IDLE.
- Results and flags hold until the next accepted start's DONE. They are not cleared on start; busy qualifies them.
- Divide by zero (dataB==0, op DIV) at accept:
  - skip CALC and go directly to DONE at E1;
  - res_lo=all ones, res_hi=dataA, cout=1, zout=0, nout=1.
- start while busy is ignored and not queued. start in the DONE cycle is also ignored.
- start held high continuously gives a new accept each time the FSM reaches IDLE.
- op/dataA/dataB changes after accept have no effect.

Optional Feature:
Macro MULDIV_SIGNED_EN.
- Defined:
  - op[1]=1 selects two's-complement operation. Operands are abs-valued at accept and the operand signs are recorded.
  - A FIX state (one cycle, after CALC) negates results: product if signs differ; quotient if signs differ; remainder takes the dividend's sign (truncating division).
  - Latency becomes accept+10 for all ops, signed or not, so timing is deterministic.
  - Signed MUL: cout = res_hi is not the sign-extension of res_lo[7].
  - Signed DIV: -128/-1 gives quotient 0x80, remainder 0, cout=1.
  - Divide-by-zero is unchanged.
- Undefined: op[1] is ignored (all ops unsigned), no FIX state exists, latency is accept+9.

Decomposition:
- Shared package muldiv_pkg holds:
  - op encodings OP_MUL=0, OP_DIV=1 and the OP_SIGNED bit index;
  - state encoding (IDLE, CALC, FIX, DONE);
  - DIV0_QUOT constant (all ones).
- One natural sub-module: muldiv_signfix, the combinational conditional negate/sign-correction used by FIX. It is instantiated only under MULDIV_SIGNED_EN.
- Datapath and FSM otherwise stay in muldiv_unit.

Test Plan:
1. MUL 0x0F*0x11, start at E0 → done pulse one cycle after E8; res_hi=0x00, res_lo=0xFF, cout=0, zout=0, nout=0; busy high E0+..E9.
2. MUL 0xFF*0xFF → res_hi=0xFE, res_lo=0x01, cout=1, nout=1; MUL 0x00*0x37 → zout=1, cout=0.
3. DIV 100/7 (0x64/0x07) → res_lo=0x0E, res_hi=0x02, cout=0; DIV 0x05/0x09 → res_lo=0x00, res_hi=0x05, zout=1.
4. DIV 0x55/0x00 → done one cycle after E1; res_lo=0xFF, res_hi=0x55, cout=1, nout=1.
5. Start DIV, pulse start with new operands at E3, assert rst at E5 → second start ignored; rst leaves IDLE with all outputs 0 and no done; a fresh MUL 0x03*0x04 then gives 0x000C.
6. (MULDIV_SIGNED_EN) signed MUL 0xFE*0x03 → 0xFFFA, cout=0, nout=1. Signed DIV 0xF9/0x02 (-7/2) → res_lo=0xFD, res_hi=0xFF. Signed DIV 0x80/0xFF → res_lo=0x80, res_hi=0x00, cout=1. All done one cycle after E9.
